pe_weight_loader: RTL and testbench

PE_WEIGHT_LOADER -- requirements
Module: pe_weight_loader

---
 rtl/pe_weight_loader_pkg.sv | 37 +++
 rtl/pe_weight_loader_shifter.sv | 60 ++++++
 rtl/pe_weight_loader.sv | 85 ++++++++
 tb/tb_pe_weight_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_weight_loader_pkg.sv
// Shared types and helpers for the ternary weight loader: FSM states, 2-bit code
// constants and the code-to-weight decode.
package pe_weight_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [1:0] CODE_ZERO    = 2'b00;
   localparam logic [1:0] CODE_POS     = 2'b01;
   localparam logic [1:0] CODE_NEG     = 2'b11;
   localparam logic [1:0] CODE_ILLEGAL = 2'b10;

   localparam int DEFAULT_WPW = 16;

   typedef struct packed {
      logic signed [1:0] weight;
      logic              illegal;
   } decoded_t;

   // Illegal codes decode to a zero weight so the PE chain never sees garbage.
   function automatic decoded_t decode(input logic [1:0] code);
      decoded_t d;
      d.weight  = 2'sd0;
      d.illegal = 1'b0;
      case (code)
         CODE_POS:     d.weight  = 2'sd1;
         CODE_NEG:     d.weight  = -2'sd1;
         CODE_ILLEGAL: d.illegal = 1'b1;
         default:      d.weight  = 2'sd0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pe_weight_loader_shifter.sv
// Word register plus code index: unpacks one packed word into WPW registered
// ternary weights, LSB code first.
module ternary_unpack_shifter
   import pe_weight_loader_pkg::*;
#(
   parameter int WPW = DEFAULT_WPW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load,
   input  logic [2*WPW-1:0]     data,
   output logic                 can_load,
   output logic                 weight_read,
   output logic signed [1:0]    weight_in,
   output logic                 illegal
);

   localparam int CW = (WPW > 1) ? $clog2(WPW) : 1;

   logic [2*WPW-1:0] word;
   logic [CW-1:0]    remain;
   logic [1:0]       code;
   decoded_t         dec;

   // remain counts codes still held after the one currently on the outputs, so
   // zero means the buffer is either empty or showing its last code.
   assign can_load = (remain == '0);

   always_comb begin
      code = load ? data[1:0] : word[1:0];
      dec  = decode(code);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         word        <= '0;
         remain      <= '0;
         weight_read <= 1'b0;
         weight_in   <= 2'sd0;
         illegal     <= 1'b0;
      end else if (load) begin
         word        <= data >> 2;
         remain      <= CW'(WPW - 1);
         weight_read <= 1'b1;
         weight_in   <= dec.weight;
         illegal     <= dec.illegal;
      end else if (remain != '0) begin
         word        <= word >> 2;
         remain      <= remain - 1'b1;
         weight_read <= 1'b1;
         weight_in   <= dec.weight;
         illegal     <= dec.illegal;
      end else begin
         weight_read <= 1'b0;
         weight_in   <= 2'sd0;
         illegal     <= 1'b0;
      end
   end

endmodule

// File: rtl/pe_weight_loader.sv
// Tile-level ternary weight loader: accepts num_words packed words and streams
// their codes to the PE chain one per cycle, then pulses done.
module pe_weight_loader
   import pe_weight_loader_pkg::*;
#(
   parameter int WPW   = DEFAULT_WPW,
   parameter int LEN_W = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LEN_W-1:0]     num_words,
   input  logic                 in_valid,
   input  logic [2*WPW-1:0]     in_data,
   output logic                 in_ready,
   output logic                 weight_read,
   output logic signed [1:0]    weight_in,
   output logic                 busy,
   output logic                 done,
   output logic                 err_illegal
);

   state_t           state, state_nx;
   logic [LEN_W-1:0] words_left;
   logic             err_q;
   logic             can_load;
   logic             accept;
   logic             illegal_now;

   assign in_ready    = (state == STREAM) && (words_left != '0) && can_load;
   assign accept      = in_valid && in_ready;
   // The registered sticky bit lags by a cycle; OR in the live flag so the
   // error shows alongside the offending weight.
   assign err_illegal = err_q | illegal_now;

   ternary_unpack_shifter #(.WPW(WPW)) u_shifter (
      .clock       (clock),
      .reset       (reset),
      .load        (accept),
      .data        (in_data),
      .can_load    (can_load),
      .weight_read (weight_read),
      .weight_in   (weight_in),
      .illegal     (illegal_now)
   );

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = (num_words == '0) ? DONE : STREAM;
         end
         STREAM: begin
            busy = 1'b1;
            if ((words_left == '0) && can_load) state_nx = DONE;
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         words_left <= '0;
         err_q      <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == IDLE) && start) begin
            words_left <= num_words;
            err_q      <= 1'b0;
         end else begin
            if (accept)      words_left <= words_left - 1'b1;
            if (illegal_now) err_q      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Randomized bench for pe_weight_loader against a queue-based model of the
// tile stream: each accepted word expands into WPW codes emitted in order.
module tb_pe_weight_loader;

   localparam int WPW   = 16;
   localparam int LEN_W = 8;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    start;
   logic [LEN_W-1:0]        num_words;
   logic                    in_valid;
   logic [2*WPW-1:0]        in_data;
   logic                    in_ready;
   logic                    weight_read;
   logic signed [1:0]       weight_in;
   logic                    busy;
   logic                    done;
   logic                    err_illegal;

   pe_weight_loader #(.WPW(WPW), .LEN_W(LEN_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .num_words   (num_words),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .weight_read (weight_read),
      .weight_in   (weight_in),
      .busy        (busy),
      .done        (done),
      .err_illegal (err_illegal)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // model: 0 idle, 1 streaming, 2 done; q holds codes not yet shown
   int m_st = 0;
   int m_words = 0;
   int q[$];
   bit m_rd = 0;
   int m_w = 0;
   bit m_err = 0;
   int acc_cnt = 0;
   int m_idle = 0;

   int rd_cnt, done_cnt, gap;
   bit seen_rd;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return (m_st == 1) && (m_words > 0) && (q.size() == 0);
   endfunction

   function automatic logic [31:0] legal_word();
      logic [31:0] w;
      int c;
      w = '0;
      for (int i = 0; i < WPW; i++) begin
         c = $urandom_range(2);
         w[2*i +: 2] = (c == 2) ? 2'b11 : 2'(c);
      end
      return w;
   endfunction

   task automatic step();
      bit acc;
      int nst, c;
      if (reset) begin
         m_st = 0; q.delete(); m_words = 0; m_rd = 0; m_w = 0; m_err = 0;
         return;
      end
      acc = in_valid && m_ready();
      nst = m_st;
      case (m_st)
         0: if (start) begin
               nst = (num_words == 0) ? 2 : 1;
               m_words = int'(num_words);
               m_err = 0;
            end
         1: if (m_words == 0 && q.size() == 0) nst = 2;
         default: nst = 0;
      endcase
      if (acc) begin
         for (int i = 0; i < WPW; i++) q.push_back(int'((in_data >> (2*i)) & 32'h3));
         m_words--;
         acc_cnt++;
      end
      if (q.size() > 0) begin
         c = q.pop_front();
         m_rd = 1;
         m_w = (c == 1) ? 1 : (c == 3) ? -1 : 0;
         if (c == 2) m_err = 1;
      end else begin
         m_rd = 0;
         m_w = 0;
      end
      m_st = nst;
   endtask

   task automatic cyc();
      int w;
      @(posedge clock);
      step();
      @(negedge clock);
      w = weight_in;
      chk("in_ready", int'(in_ready), int'(m_ready()));
      chk("weight_read", int'(weight_read), int'(m_rd));
      chk("weight_in", w, m_w);
      chk("busy", int'(busy), int'(m_st != 0));
      chk("done", int'(done), int'(m_st == 2));
      chk("err_illegal", int'(err_illegal), int'(m_err));
      rd_cnt += int'(weight_read);
      done_cnt += int'(done);
      if (seen_rd && busy && !done && !weight_read) gap++;
      if (weight_read) seen_rd = 1;
      if (m_st == 1 && !m_rd && acc_cnt >= 1) m_idle++;
   endtask

   // vprob: percent chance of in_valid per cycle; -1 = starve 5 cycles after word 1
   // mode: 0 legal random, 1 first word 0x35, 2 illegal code at index 3, 3 any codes
   task automatic run_tile(input int num, input int vprob, input int mode, input bit inj);
      logic [31:0] words[$];
      logic [31:0] w;
      int n;
      for (int i = 0; i < num; i++) begin
         w = (mode == 3) ? $urandom : legal_word();
         if (i == 0 && mode == 1) w = 32'h0000_0035;
         if (i == 0 && mode == 2) w[7:6] = 2'b10;
         words.push_back(w);
      end
      rd_cnt = 0; done_cnt = 0; gap = 0; seen_rd = 0; acc_cnt = 0; m_idle = 0;
      start = 1; num_words = LEN_W'(num); in_valid = 0;
      cyc();
      start = 0; num_words = LEN_W'($urandom);
      n = 0;
      while (m_st != 0 && n < 3000) begin
         if (vprob < 0) in_valid = (acc_cnt == 0) || (m_idle >= 5);
         else in_valid = ($urandom_range(99) < vprob);
         in_data = (acc_cnt < num) ? words[acc_cnt] : $urandom;
         start = inj && (m_st == 1) && ($urandom_range(3) == 0);
         cyc();
         n++;
      end
      start = 0; in_valid = 0;
      if (n >= 3000) chk("timeout", n, 0);
      chk("reads", rd_cnt, num * WPW);
      chk("dones", done_cnt, 1);
      if (vprob == 100) chk("gap", gap, 0);
      if (vprob < 0) chk("gap", gap, 5);
   endtask

   task automatic mid_reset();
      logic [31:0] w0;
      int n;
      w0 = legal_word();
      rd_cnt = 0; done_cnt = 0; gap = 0; seen_rd = 0; acc_cnt = 0;
      start = 1; num_words = 8'd2; in_valid = 0;
      cyc();
      start = 0; in_valid = 1; in_data = w0;
      n = 0;
      while (rd_cnt < 8 && n < 100) begin
         cyc();
         n++;
      end
      if (n >= 100) chk("rst_timeout", n, 0);
      reset = 1;
      cyc();
      reset = 0; in_valid = 0;
      chk("rst_rd", int'(weight_read), 0);
      chk("rst_w", int'(weight_in), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 0);
      done_cnt = 0;
      for (int i = 0; i < 4; i++) cyc();
      chk("rst_nodone", done_cnt, 0);
   endtask

   initial begin
      reset = 1; start = 0; in_valid = 0; in_data = '0; num_words = '0;
      rd_cnt = 0; done_cnt = 0; gap = 0; seen_rd = 0;
      cyc();
      start = 1; in_valid = 1; num_words = 8'd3;
      cyc();
      chk("rst_err", int'(err_illegal), 0);
      chk("rst_done", int'(done), 0);
      reset = 0; start = 0; in_valid = 0;
      cyc();

      run_tile(1, 100, 1, 0);
      run_tile(3, 100, 0, 0);
      run_tile(2, -1, 0, 0);
      run_tile(2, 100, 2, 0);
      cyc(); cyc();
      run_tile(0, 100, 0, 0);
      run_tile(3, 60, 0, 1);
      mid_reset();
      run_tile(1, 100, 0, 0);
      for (int k = 0; k < 20; k++) begin
         run_tile($urandom_range(4), $urandom_range(30, 100), 3, 1'($urandom_range(1)));
         for (int i = 0; i < int'($urandom_range(2)); i++) cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
